// File: rtl/rv_lsu_bridge.sv
// rv_lsu_bridge: registered load/store bridge from a single-cycle core data port to a valid/ready bus.
// Define LSU_TIMEOUT_EN to abort accesses that exceed TIMEOUT_CYC cycles with a cpu_err pulse.
module rv_lsu_bridge #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [2:0]          cpu_strb,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [XLEN-1:0]     cpu_wdata,
  output logic [XLEN-1:0]     cpu_rdata,
  output logic                cpu_stall,
  output logic                cpu_done,
  output logic                cpu_misalign,
  output logic                cpu_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_wmask,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("rv_lsu_bridge: unsupported parameters");
  end

  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;

  state_t            state, state_nx;
  logic [OW-1:0]     off_q, off_nx, off_in;
  logic [2:0]        strb_q, strb_nx;
  logic              valid_nx, we_nx, done_nx, mis_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [NB-1:0]     wmask_nx, wm;
  logic [XLEN-1:0]   wdata_nx, rdata_nx, lanes, wd_sh, rd_sh, ext;
  logic [7:0]        m8;
  logic              mis, busy, tmo;

  // Illegal size codes are folded into the misalign reject so they never reach the bus.
  assign mis = cpu_strb == 3'b111 || (cpu_we && cpu_strb[2]) ||
               (XLEN == 32 && (cpu_strb[1:0] == 2'b11 || cpu_strb == 3'b110)) ||
               (cpu_strb[1:0] == 2'b01 && cpu_addr[0]) ||
               (cpu_strb[1:0] == 2'b10 && cpu_addr[1:0] != 2'b00) ||
               (cpu_strb[1:0] == 2'b11 && cpu_addr[2:0] != 3'b000);

  assign busy      = state == REQ || state == RWAIT;
  assign cpu_stall = busy || (state == IDLE && cpu_req && !mis);

  assign off_in = cpu_addr[OW-1:0];
  assign m8     = cpu_strb[1:0] == 2'b00 ? 8'h01 :
                  cpu_strb[1:0] == 2'b01 ? 8'h03 :
                  cpu_strb[1:0] == 2'b10 ? 8'h0F : 8'hFF;
  assign wm     = cpu_we ? m8[NB-1:0] << off_in : '0;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign lanes[8*i +: 8] = {8{wm[i]}};
  end

  assign wd_sh = (cpu_wdata << {off_in, 3'b000}) & lanes;
  assign rd_sh = mem_rdata >> {off_q, 3'b000};
  assign ext   = strb_q == 3'b000 ? XLEN'($signed(rd_sh[7:0])) :
                 strb_q == 3'b001 ? XLEN'($signed(rd_sh[15:0])) :
                 strb_q == 3'b010 ? XLEN'($signed(rd_sh[31:0])) :
                 strb_q == 3'b100 ? XLEN'(rd_sh[7:0]) :
                 strb_q == 3'b101 ? XLEN'(rd_sh[15:0]) :
                 strb_q == 3'b110 ? XLEN'(rd_sh[31:0]) : rd_sh;

  always_comb begin
    state_nx = state;
    valid_nx = mem_valid;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wmask_nx = mem_wmask;
    wdata_nx = mem_wdata;
    rdata_nx = cpu_rdata;
    off_nx   = off_q;
    strb_nx  = strb_q;
    done_nx  = 1'b0;
    mis_nx   = 1'b0;
    if (tmo) begin
      state_nx = DONE;
      valid_nx = 1'b0;
      done_nx  = 1'b0 | 1'b1;
      rdata_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          mis_nx = cpu_req && mis;
          if (cpu_req && !mis) begin
            state_nx = REQ;
            valid_nx = 1'b1;
            we_nx    = cpu_we;
            addr_nx  = {cpu_addr[ADDR_W-1:OW], {OW{1'b0}}};
            wmask_nx = wm;
            wdata_nx = wd_sh;
            off_nx   = off_in;
            strb_nx  = cpu_strb;
          end
        end
        REQ: if (mem_ready) begin
          valid_nx = 1'b0;
          state_nx = mem_we ? DONE : RWAIT;
          done_nx  = mem_we;
        end
        RWAIT: if (mem_rvalid) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          rdata_nx = ext;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= IDLE;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wmask    <= '0;
      mem_wdata    <= '0;
      cpu_rdata    <= '0;
      cpu_done     <= 1'b0;
      cpu_misalign <= 1'b0;
      off_q        <= '0;
      strb_q       <= '0;
    end else begin
      state        <= state_nx;
      mem_valid    <= valid_nx;
      mem_we       <= we_nx;
      mem_addr     <= addr_nx;
      mem_wmask    <= wmask_nx;
      mem_wdata    <= wdata_nx;
      cpu_rdata    <= rdata_nx;
      cpu_done     <= done_nx;
      cpu_misalign <= mis_nx;
      off_q        <= off_nx;
      strb_q       <= strb_nx;
    end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt;

  // Counter restarts on every capture, so each access gets its own TIMEOUT_CYC budget.
  assign tmo = busy && cnt == CW'(TIMEOUT_CYC - 1);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt     <= '0;
      cpu_err <= 1'b0;
    end else begin
      cnt     <= busy ? cnt + 1'b1 : '0;
      cpu_err <= tmo;
    end
`else
  assign tmo     = 1'b0;
  assign cpu_err = 1'b0;
`endif
endmodule

// File: tb/tb_rv_lsu_bridge.sv
// tb_rv_lsu_bridge: directed vector table over 32- and 64-bit bridges plus multi-cycle sequences.
module tb_rv_lsu_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, we, w64, ready, rvalid;
  logic [2:0]  strb;
  logic [31:0] addr;
  logic [63:0] wdata, rdata_bus;

  logic [31:0] rd32, wd32, a32, a64;
  logic [63:0] rd64, wd64;
  logic [3:0]  wm32;
  logic [7:0]  wm64;
  logic        st32, dn32, ms32, er32, v32, we32;
  logic        st64, dn64, ms64, er64, v64, we64;

  logic [63:0] o_rdata, o_wdata;
  logic [31:0] o_addr;
  logic [7:0]  o_wmask;
  logic        o_valid, o_we, o_stall, o_done, o_mis, o_err;

  assign o_rdata = w64 ? rd64 : {32'b0, rd32};
  assign o_wdata = w64 ? wd64 : {32'b0, wd32};
  assign o_wmask = w64 ? wm64 : {4'b0, wm32};
  assign o_addr  = w64 ? a64 : a32;
  assign o_valid = w64 ? v64 : v32;
  assign o_we    = w64 ? we64 : we32;
  assign o_stall = w64 ? st64 : st32;
  assign o_done  = w64 ? dn64 : dn32;
  assign o_mis   = w64 ? ms64 : ms32;
  assign o_err   = w64 ? er64 : er32;

  rv_lsu_bridge #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .cpu_req(req & ~w64), .cpu_we(we), .cpu_strb(strb),
    .cpu_addr(addr), .cpu_wdata(wdata[31:0]), .cpu_rdata(rd32), .cpu_stall(st32),
    .cpu_done(dn32), .cpu_misalign(ms32), .cpu_err(er32), .mem_valid(v32),
    .mem_ready(ready), .mem_we(we32), .mem_addr(a32), .mem_wmask(wm32),
    .mem_wdata(wd32), .mem_rvalid(rvalid), .mem_rdata(rdata_bus[31:0])
  );

  rv_lsu_bridge #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .cpu_req(req & w64), .cpu_we(we), .cpu_strb(strb),
    .cpu_addr(addr), .cpu_wdata(wdata), .cpu_rdata(rd64), .cpu_stall(st64),
    .cpu_done(dn64), .cpu_misalign(ms64), .cpu_err(er64), .mem_valid(v64),
    .mem_ready(ready), .mem_we(we64), .mem_addr(a64), .mem_wmask(wm64),
    .mem_wdata(wd64), .mem_rvalid(rvalid), .mem_rdata(rdata_bus)
  );

  typedef struct {
    logic        w64;
    logic        we;
    logic [2:0]  strb;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] bus;
    int          wt;
    logic        is_mis;
    int          lat;
    logic [31:0] maddr;
    logic [7:0]  wm;
    logic [63:0] wd;
    logic [63:0] rd;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0, n_fail = 0;

  function automatic vec_t mk(input logic w, input logic st, input logic [2:0] s,
                              input logic [31:0] a, input logic [63:0] di, input logic [63:0] bus,
                              input int wt, input logic m, input int lat, input logic [31:0] ma,
                              input logic [7:0] wm, input logic [63:0] wd, input logic [63:0] rd);
    return '{w, st, s, a, di, bus, wt, m, lat, ma, wm, wd, rd};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    int done_c = -1, done_n = 0, mis_n = 0, vcnt = 0, err_n = 0;
    logic acc = 1'b0, stall0 = 1'b0, mwe = 1'b0;
    logic [63:0] rd = '0, wd = '0;
    logic [31:0] ma = '0;
    logic [7:0]  wm = '0;
    @(posedge clk); #1;
    w64 = t.w64; req = 1'b1; we = t.we; strb = t.strb; addr = t.addr;
    wdata = t.wdata; rdata_bus = t.bus; ready = 1'b0; rvalid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) stall0 = o_stall;
      if (o_mis) mis_n++;
      if (o_err) err_n++;
      if (o_done) begin
        done_n++;
        if (done_c < 0) begin done_c = c; rd = o_rdata; end
      end
      if (o_valid) begin
        vcnt++; ma = o_addr; wm = o_wmask; wd = o_wdata; mwe = o_we;
      end
      ready  = o_valid && vcnt > t.wt;
      rvalid = acc;
      if (o_valid && ready && !o_we) acc = 1'b1;
      if ((t.is_mis && c >= 1) || done_c >= 0) req = 1'b0;
      if ((done_c >= 0 && c > done_c) || (t.is_mis && c >= 3)) break;
    end
    req = 1'b0; ready = 1'b0; rvalid = 1'b0;
    if (t.is_mis) begin
      chk($sformatf("v%0d misalign pulses", idx), 64'(mis_n), 64'd1);
      chk($sformatf("v%0d valid cycles", idx), 64'(vcnt), 64'd0);
      chk($sformatf("v%0d stall", idx), 64'(stall0), 64'd0);
      chk($sformatf("v%0d done pulses", idx), 64'(done_n), 64'd0);
    end else begin
      chk($sformatf("v%0d stall", idx), 64'(stall0), 64'd1);
      chk($sformatf("v%0d done pulses", idx), 64'(done_n), 64'd1);
      chk($sformatf("v%0d latency", idx), 64'(done_c), 64'(t.lat));
      chk($sformatf("v%0d valid cycles", idx), 64'(vcnt), 64'(t.wt + 1));
      chk($sformatf("v%0d mem_addr", idx), 64'(ma), 64'(t.maddr));
      chk($sformatf("v%0d mem_wmask", idx), 64'(wm), 64'(t.wm));
      chk($sformatf("v%0d mem_wdata", idx), wd, t.wd);
      chk($sformatf("v%0d mem_we", idx), 64'(mwe), 64'(t.we));
      chk($sformatf("v%0d misalign", idx), 64'(mis_n), 64'd0);
      chk($sformatf("v%0d err", idx), 64'(err_n), 64'd0);
      if (!t.we) chk($sformatf("v%0d cpu_rdata", idx), rd, t.rd);
    end
  endtask

  logic [31:0] mw;
  logic [63:0] rd_h;
  int          sd, ld, dn, vc;
  logic        ovl, err_h;

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; w64 = 1'b0; ready = 1'b0; rvalid = 1'b0;
    strb = 3'b000; addr = '0; wdata = '0; rdata_bus = '0;

    vt.push_back(mk(0, 0, 3'b000, 32'h1003, 0, 64'h80AABBCC, 0, 0, 3, 32'h1000, 8'h0, 0, 64'hFFFFFF80));
    vt.push_back(mk(0, 0, 3'b100, 32'h1003, 0, 64'h80AABBCC, 0, 0, 3, 32'h1000, 8'h0, 0, 64'h00000080));
    vt.push_back(mk(0, 1, 3'b001, 32'h2002, 64'h1234ABCD, 0, 3, 0, 5, 32'h2000, 8'hC, 64'hABCD0000, 0));
    vt.push_back(mk(0, 0, 3'b010, 32'h3001, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 3'b001, 32'h1002, 0, 64'h80AABBCC, 0, 0, 3, 32'h1000, 8'h0, 0, 64'hFFFF80AA));
    vt.push_back(mk(0, 0, 3'b101, 32'h1000, 0, 64'h80AABBCC, 0, 0, 3, 32'h1000, 8'h0, 0, 64'h0000BBCC));
    vt.push_back(mk(0, 0, 3'b010, 32'h1004, 0, 64'h80AABBCC, 2, 0, 5, 32'h1004, 8'h0, 0, 64'h80AABBCC));
    vt.push_back(mk(0, 0, 3'b000, 32'h1001, 0, 64'h80AABBCC, 0, 0, 3, 32'h1000, 8'h0, 0, 64'hFFFFFFBB));
    vt.push_back(mk(0, 1, 3'b000, 32'h6001, 64'hFFFFFF5A, 0, 0, 0, 2, 32'h6000, 8'h2, 64'h00005A00, 0));
    vt.push_back(mk(0, 1, 3'b010, 32'h6004, 64'hDEADBEEF, 0, 0, 0, 2, 32'h6004, 8'hF, 64'hDEADBEEF, 0));
    vt.push_back(mk(0, 0, 3'b011, 32'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 3'b110, 32'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 3'b100, 32'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 0, 3'b111, 32'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 3'b001, 32'h2001, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 3'b110, 32'h4004, 0, 64'hDEADBEEF_00000000, 0, 0, 3, 32'h4000, 8'h0, 0, 64'h00000000_DEADBEEF));
    vt.push_back(mk(1, 0, 3'b010, 32'h4004, 0, 64'hDEADBEEF_00000000, 0, 0, 3, 32'h4000, 8'h0, 0, 64'hFFFFFFFF_DEADBEEF));
    vt.push_back(mk(1, 1, 3'b011, 32'h4008, 64'h01234567_89ABCDEF, 0, 0, 0, 2, 32'h4008, 8'hFF, 64'h01234567_89ABCDEF, 0));
    vt.push_back(mk(1, 0, 3'b011, 32'h4008, 0, 64'h01234567_89ABCDEF, 1, 0, 4, 32'h4008, 8'h0, 0, 64'h01234567_89ABCDEF));
    vt.push_back(mk(1, 1, 3'b010, 32'h400C, 64'h00000000_CAFEBABE, 0, 0, 0, 2, 32'h4008, 8'hF0, 64'hCAFEBABE_00000000, 0));
    vt.push_back(mk(1, 0, 3'b011, 32'h4004, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 0, 3'b000, 32'h4007, 0, 64'h7F000000_00000000, 0, 0, 3, 32'h4000, 8'h0, 0, 64'h7F));
`ifndef LSU_TIMEOUT_EN
    vt.push_back(mk(0, 1, 3'b010, 32'h6008, 64'h55AA55AA, 0, 70, 0, 72, 32'h6008, 8'hF, 64'h55AA55AA, 0));
`endif

    @(negedge clk); @(negedge clk);
    chk("rst v32", 64'(v32), 0);
    chk("rst v64", 64'(v64), 0);
    chk("rst done", 64'({dn32, dn64}), 0);
    chk("rst mis", 64'({ms32, ms64}), 0);
    chk("rst err", 64'({er32, er64}), 0);
    chk("rst stall", 64'({st32, st64}), 0);
    chk("rst rdata", {rd32, rd64[31:0]} | rd64, 0);
    chk("rst mem_addr", {a32, a64}, 0);
    chk("rst wmask", 64'({wm32, wm64, we32, we64}), 0);
    chk("rst wdata", {wd32, wd64[31:0]} | wd64, 0);
    reset = 1'b1;

    foreach (vt[i]) run(vt[i], i);

    // Back-to-back SW then LW through a one-word memory model, zero-wait bus.
    mw = 32'h11111111; sd = -1; ld = -1; ovl = 1'b0; rd_h = '0;
    @(posedge clk); #1;
    w64 = 1'b0; req = 1'b1; we = 1'b1; strb = 3'b010; addr = 32'h5000;
    wdata = 64'hCAFEF00D; rdata_bus = {32'b0, mw}; ready = 1'b1; rvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (o_valid && o_done) ovl = 1'b1;
      if (o_valid && o_we)
        for (int b = 0; b < 4; b++) if (o_wmask[b]) mw[8*b +: 8] = o_wdata[8*b +: 8];
      rdata_bus = {32'b0, mw};
      if (o_done) begin
        if (sd < 0) begin sd = c; we = 1'b0; end
        else begin ld = c; rd_h = o_rdata; break; end
      end
    end
    req = 1'b0; ready = 1'b0; rvalid = 1'b0;
    chk("b2b store done cycle", 64'(sd), 64'd2);
    chk("b2b load done cycle", 64'(ld), 64'd6);
    chk("b2b load data", rd_h, 64'hCAFEF00D);
    chk("b2b done with valid", 64'(ovl), 0);

`ifdef LSU_TIMEOUT_EN
    // No mem_ready ever: abort after TIMEOUT_CYC cycles in REQ.
    dn = -1; err_h = 1'b0; rd_h = '1;
    @(posedge clk); #1;
    w64 = 1'b0; req = 1'b1; we = 1'b0; strb = 3'b010; addr = 32'h8000; ready = 1'b0; rvalid = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (o_done) begin dn = c; err_h = o_err; rd_h = o_rdata; req = 1'b0; break; end
    end
    req = 1'b0;
    chk("timeout done cycle", 64'(dn), 64'd65);
    chk("timeout err with done", 64'(err_h), 64'd1);
    chk("timeout rdata", rd_h, 0);
    ready = 1'b1; rvalid = 1'b1; vc = 0; dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_valid) vc++;
      if (o_done || o_err) dn++;
    end
    ready = 1'b0; rvalid = 1'b0;
    chk("timeout late bus valid", 64'(vc), 0);
    chk("timeout late done", 64'(dn), 0);
`endif

    // Reset during REQ, then during RWAIT.
    @(posedge clk); #1;
    w64 = 1'b0; req = 1'b1; we = 1'b0; strb = 3'b010; addr = 32'h7000; ready = 1'b0; rvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst-req valid before", 64'(o_valid), 64'd1);
    #1 req = 1'b0; reset = 1'b0;
    #1 chk("rst-req valid drops", 64'(o_valid), 0);
    chk("rst-req idle", 64'(o_stall), 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1 req = 1'b1; ready = 1'b1;
    @(negedge clk); @(negedge clk);
    @(negedge clk);
    chk("rst-rwait stall", 64'(o_stall), 64'd1);
    chk("rst-rwait valid", 64'(o_valid), 0);
    #1 req = 1'b0; reset = 1'b0; ready = 1'b0;
    #1 chk("rst-rwait idle", 64'(o_stall), 0);
    @(negedge clk) reset = 1'b1;
    rvalid = 1'b1; dn = 0; vc = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) dn++;
      if (o_valid) vc++;
    end
    rvalid = 1'b0;
    chk("rst-rwait no done", 64'(dn), 0);
    chk("rst-rwait no valid", 64'(vc), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
